// File: rtl/fir_pkg.sv
// fir_pkg: loader FSM states and the coefficient width shared with the FIR
package fir_pkg;
  localparam int COEF_W = 12;
  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_t;
endpackage

// File: rtl/fir_tap_loader_if.sv
// fir_tap_loader_if: host coefficient port, load request and FIR tap-write port
interface fir_tap_loader_if import fir_pkg::*; #(
  parameter int NTAPS = 16,
  parameter int IW = COEF_W,
  parameter int AW = $clog2(NTAPS)
);
  logic i_coef_wr;
  logic i_coef_bank;
  logic [AW-1:0] i_coef_addr;
  logic [IW-1:0] i_coef_data;
  logic i_load;
  logic i_load_bank;
  logic o_tap_wr;
  logic [IW-1:0] o_tap;
  logic o_busy;
  logic o_done;
  logic o_active_bank;
  logic o_err;
  modport master (
    output i_coef_wr, i_coef_bank, i_coef_addr, i_coef_data, i_load, i_load_bank,
    input o_tap_wr, o_tap, o_busy, o_done, o_active_bank, o_err
  );
  modport slave (
    input i_coef_wr, i_coef_bank, i_coef_addr, i_coef_data, i_load, i_load_bank,
    output o_tap_wr, o_tap, o_busy, o_done, o_active_bank, o_err
  );
endinterface

// File: rtl/fir_coef_ram.sv
// fir_coef_ram: two-bank coefficient store, one write port and one synchronous read port
module fir_coef_ram import fir_pkg::*; #(
  parameter int AW = 5,
  parameter int IW = COEF_W
) (
  input  logic clk,
  input  logic we,
  input  logic [AW-1:0] wa,
  input  logic [IW-1:0] wd,
  input  logic re,
  input  logic [AW-1:0] ra,
  output logic [IW-1:0] rd
);
  logic [IW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end
endmodule

// File: rtl/fir_tap_loader.sv
// fir_tap_loader: streams one ping-pong coefficient bank into the FIR tap port,
// last coefficient first, so h[k] lands in FIR tap k.
module fir_tap_loader import fir_pkg::*; #(
  parameter int NTAPS = 16,
  parameter int IW = COEF_W,
  parameter int AW = $clog2(NTAPS)
) (
  input logic i_clk,
  input logic i_reset,
  fir_tap_loader_if.slave bus
);
  state_t state;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] rd_data;
  logic bank, rd_last, load_q;
  logic rd_en, wr_err, wr_ok, load_err;
  assign rd_en = state == PRIME || state == STREAM;
  assign wr_err = bus.i_coef_wr && bus.o_busy && bus.i_coef_bank == bank;
  assign wr_ok = bus.i_coef_wr && !wr_err && int'(bus.i_coef_addr) < NTAPS;
  // only a fresh request is an error; a level held from IDLE just chains loads
  assign load_err = bus.i_load && !load_q && state != IDLE;
  fir_coef_ram #(.AW(AW + 1), .IW(IW)) u_ram (
    .clk(i_clk),
    .we(wr_ok),
    .wa({bus.i_coef_bank, bus.i_coef_addr}),
    .wd(bus.i_coef_data),
    .re(rd_en),
    .ra({bank, rd_addr}),
    .rd(rd_data)
  );
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      rd_addr <= '0;
      bank <= 1'b0;
      rd_last <= 1'b0;
      load_q <= 1'b0;
      bus.o_tap_wr <= 1'b0;
      bus.o_tap <= '0;
      bus.o_busy <= 1'b0;
      bus.o_done <= 1'b0;
      bus.o_active_bank <= 1'b0;
      bus.o_err <= 1'b0;
    end else begin
      load_q <= bus.i_load;
      bus.o_err <= load_err || wr_err;
      bus.o_done <= 1'b0;
      // rd_data holds h[0] on the cycle after address 0 was read
      rd_last <= rd_en && rd_addr == '0;
      case (state)
        IDLE: if (bus.i_load) begin
          state <= PRIME;
          bus.o_busy <= 1'b1;
          bank <= bus.i_load_bank;
          rd_addr <= AW'(NTAPS - 1);
        end
        PRIME: begin
          state <= STREAM;
          rd_addr <= rd_addr - AW'(1);
        end
        STREAM: begin
          bus.o_tap_wr <= 1'b1;
          bus.o_tap <= rd_data;
          if (rd_addr != '0) rd_addr <= rd_addr - AW'(1);
          if (rd_last) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          bus.o_tap_wr <= 1'b0;
          bus.o_done <= 1'b1;
          bus.o_busy <= 1'b0;
          bus.o_active_bank <= bank;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_tap_loader.sv
// tb_fir_tap_loader: table vectors, hand-written corner sequences and random loads
// checked against a bank-array reference model and a shift-in FIR model.
module tb_fir_tap_loader;
  import fir_pkg::*;
  localparam int N = 4;
  localparam int W = 12;
  typedef struct packed {
    logic bank;
    logic [N-1:0][W-1:0] h;
    logic [N-1:0][W-1:0] taps;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] ref_mem [2][N];
  logic [W-1:0] got [N];
  logic [W-1:0] fir [N];
  bit ref_active = 1'b0;
  vec_t tbl [3];
  always #5 clk = ~clk;
  fir_tap_loader_if #(.NTAPS(N), .IW(W)) bus ();
  fir_tap_loader #(.NTAPS(N), .IW(W)) dut (.i_clk(clk), .i_reset(rst), .bus(bus));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic hw(input bit b, input int a, input logic [W-1:0] d);
    bus.i_coef_wr = 1'b1;
    bus.i_coef_bank = b;
    bus.i_coef_addr = 2'(a);
    bus.i_coef_data = d;
    @(negedge clk);
    bus.i_coef_wr = 1'b0;
    ref_mem[b][a] = d;
  endtask

  // load bank b; kind 1 = host write, kind 2 = extra load, issued after sample act_i
  // (act_i = -1 puts the write in the same cycle as the load request)
  task automatic do_load(input bit b, input int act_i, input int kind, input bit wb,
                         input int wa, input logic [W-1:0] wd);
    logic [W-1:0] exp [N];
    bit prev_active;
    int err_at;
    prev_active = ref_active;
    err_at = -10;
    bus.i_load = 1'b1;
    bus.i_load_bank = b;
    if (act_i < 0 && kind == 1) begin
      bus.i_coef_wr = 1'b1;
      bus.i_coef_bank = wb;
      bus.i_coef_addr = 2'(wa);
      bus.i_coef_data = wd;
      ref_mem[wb][wa] = wd;
    end
    for (int k = 0; k < N; k++) exp[k] = ref_mem[b][N-1-k];
    for (int i = 0; i < N + 4; i++) begin
      @(negedge clk);
      chk("tap_wr", 32'(bus.o_tap_wr), 32'(i >= 2 && i <= N + 1));
      if (i >= 2 && i <= N + 1) begin
        chk("tap", 32'(bus.o_tap), 32'(exp[i-2]));
        got[i-2] = bus.o_tap;
        for (int k = N - 1; k > 0; k--) fir[k] = fir[k-1];
        fir[0] = bus.o_tap;
      end
      chk("busy", 32'(bus.o_busy), 32'(i <= N + 1));
      chk("done", 32'(bus.o_done), 32'(i == N + 2));
      chk("active", 32'(bus.o_active_bank), 32'(i >= N + 2 ? b : prev_active));
      chk("err", 32'(bus.o_err), 32'(i == err_at));
      bus.i_load = 1'b0;
      bus.i_coef_wr = 1'b0;
      if (i == act_i && kind == 1) begin
        bus.i_coef_wr = 1'b1;
        bus.i_coef_bank = wb;
        bus.i_coef_addr = 2'(wa);
        bus.i_coef_data = wd;
        if (wb == b) err_at = i + 1;
        else ref_mem[wb][wa] = wd;
      end
      if (i == act_i && kind == 2) begin
        bus.i_load = 1'b1;
        bus.i_load_bank = ~b;
        err_at = i + 1;
      end
    end
    ref_active = b;
  endtask

  initial begin
    bus.i_coef_wr = 1'b0;
    bus.i_coef_bank = 1'b0;
    bus.i_coef_addr = '0;
    bus.i_coef_data = '0;
    bus.i_load = 1'b0;
    bus.i_load_bank = 1'b0;
    tbl[0] = '{bank: 1'b0, h: {12'h004, 12'h003, 12'h002, 12'h001},
               taps: {12'h001, 12'h002, 12'h003, 12'h004}};
    tbl[1] = '{bank: 1'b1, h: {12'hFFF, 12'h123, 12'h7FF, 12'h800},
               taps: {12'h800, 12'h7FF, 12'h123, 12'hFFF}};
    tbl[2] = '{bank: 1'b0, h: {12'hA5A, 12'h000, 12'h5A5, 12'hFFE},
               taps: {12'hFFE, 12'h5A5, 12'h000, 12'hA5A}};
    repeat (3) @(negedge clk);
    chk("rst_tap_wr", 32'(bus.o_tap_wr), 0);
    chk("rst_tap", 32'(bus.o_tap), 0);
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk("rst_done", 32'(bus.o_done), 0);
    chk("rst_active", 32'(bus.o_active_bank), 0);
    chk("rst_err", 32'(bus.o_err), 0);
    rst = 1'b0;
    @(negedge clk);
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < N; k++) hw(tbl[v].bank, k, tbl[v].h[k]);
      do_load(tbl[v].bank, -1, 0, 1'b0, 0, '0);
      for (int k = 0; k < N; k++) chk("tbl_tap", 32'(got[k]), 32'(tbl[v].taps[k]));
      // impulse through a FIR built from the shifted-in taps reproduces h[0..N-1]
      for (int n = 0; n < N; n++) begin
        int y;
        y = 0;
        for (int k = 0; k < N; k++) if (n == k) y += int'($signed(fir[k]));
        chk("fir_impulse", 32'(y), 32'(int'($signed(tbl[v].h[n]))));
      end
    end
    for (int k = 0; k < N; k++) hw(1'b0, k, 12'(k + 1));
    do_load(1'b0, 2, 1, 1'b0, 1, 12'h0AA);
    do_load(1'b0, -1, 0, 1'b0, 0, '0);
    chk("discarded_wr", 32'(got[2]), 32'h002);
    do_load(1'b0, 3, 1, 1'b1, 1, 12'h7FF);
    do_load(1'b1, -1, 0, 1'b0, 0, '0);
    chk("other_bank_wr", 32'(got[2]), 32'h7FF);
    do_load(1'b0, 2, 2, 1'b0, 0, '0);
    do_load(1'b1, -1, 1, 1'b1, 3, 12'h3C3);
    chk("same_cycle_wr", 32'(got[0]), 32'h3C3);
    bus.i_load = 1'b1;
    bus.i_load_bank = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.i_load = 1'b0;
    end
    chk("pre_rst_tap_wr", 32'(bus.o_tap_wr), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_tap_wr", 32'(bus.o_tap_wr), 0);
    chk("arst_busy", 32'(bus.o_busy), 0);
    chk("arst_active", 32'(bus.o_active_bank), 0);
    chk("arst_done", 32'(bus.o_done), 0);
    @(negedge clk);
    chk("arst_no_done", 32'(bus.o_done), 0);
    rst = 1'b0;
    ref_active = 1'b0;
    do_load(1'b1, -1, 0, 1'b0, 0, '0);
    bus.i_load = 1'b1;
    bus.i_load_bank = 1'b0;
    for (int i = 0; i < 3 * (N + 3); i++) begin
      int p;
      p = i % (N + 3);
      @(negedge clk);
      chk("hold_tap_wr", 32'(bus.o_tap_wr), 32'(p >= 2 && p <= N + 1));
      if (p >= 2 && p <= N + 1) chk("hold_tap", 32'(bus.o_tap), 32'(ref_mem[0][N+1-p]));
      chk("hold_busy", 32'(bus.o_busy), 32'(p != N + 2));
      chk("hold_done", 32'(bus.o_done), 32'(p == N + 2));
      chk("hold_err", 32'(bus.o_err), 0);
      if (i == 3 * (N + 3) - 1) bus.i_load = 1'b0;
    end
    ref_active = 1'b0;
    for (int r = 0; r < 30; r++) begin
      for (int w = $urandom_range(0, 3); w > 0; w--)
        hw(1'($urandom_range(0, 1)), $urandom_range(0, N - 1), 12'($urandom));
      do_load(1'($urandom_range(0, 1)), $urandom_range(0, N + 1), $urandom_range(0, 2),
              1'($urandom_range(0, 1)), $urandom_range(0, N - 1), 12'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fir_tap_loader.md
Name: fir_tap_loader

Overview:
Coefficient source for the dynamic-tap FIR's shift-in tap port. It holds two host-writable coefficient banks (ping-pong) and, on request, streams one bank onto the FIR's tap-write/tap-data interface as NTAPS back-to-back writes. Writes run last coefficient first, so h[k] ends in FIR tap k. It also provides a sample-hold indication so the integrator can gate the FIR's sample enable during a reload.

Parameters:
NTAPS, 16, number of FIR taps / coefficients per bank (>=2)
IW, 12, coefficient width in bits, two's complement
AW, $clog2(NTAPS), coefficient address width (derived)

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_coef_wr  in  1  host coefficient write strobe
i_coef_bank  in  1  bank to write
i_coef_addr  in  AW  coefficient index k
i_coef_data  in  IW  coefficient h[k]
i_load  in  1  start streaming a bank (pulse or level; sampled in IDLE only)
i_load_bank  in  1  bank to stream, sampled with i_load
o_tap_wr  out  1  tap shift strobe to FIR
o_tap  out  IW  tap value to FIR
o_busy  out  1  load in progress; integrator holds FIR sample enable low while high
o_done  out  1  one-cycle pulse at load completion
o_active_bank  out  1  bank most recently loaded completely
o_err  out  1  one-cycle pulse on a rejected request

Behaviour:
- Reset (async, active-high): all outputs 0 immediately. FSM goes to IDLE and counters clear. RAM contents are not reset and are undefined until written.
- Storage: 2*NTAPS x IW synchronous-read RAM, addressed {bank, addr}. A write takes effect at the clock edge. Read data is valid one cycle after the address.
- FSM states: IDLE, PRIME, STREAM, DONE.
- IDLE: i_load=1 at an edge -> PRIME. At the same edge: o_busy<=1, latch bank, rd_addr<=NTAPS-1.
- PRIME: issue read of rd_addr and decrement it -> STREAM.
- STREAM: each cycle o_tap_wr<=1 and o_tap<=RAM data. Reads continue down to addr 0. After the write of h[0] is registered -> DONE.
- DONE: o_tap_wr<=0, o_done<=1 for one cycle, o_busy<=0, o_active_bank<=latched bank -> IDLE.
- Timing: with i_load sampled at edge t, o_busy is high from t. o_tap_wr is high for exactly NTAPS consecutive cycles, from edge t+2 through t+NTAPS+1, carrying h[NTAPS-1]..h[0] in that order. o_done pulses and o_busy falls at edge t+NTAPS+2.
- o_tap holds its last value when o_tap_wr=0. Consumers qualify it by o_tap_wr only.
- i_load while not IDLE: ignored, o_err pulses one cycle. The current stream is unaffected.
- Host write to the bank being streamed while o_busy=1: write discarded, o_err pulses.
- Host writes to the other bank always succeed. Host writes to any bank succeed in IDLE.
- Simultaneous i_load and i_coef_wr to the same bank in IDLE: the write is committed first. The stream then reads the new value, since the first read issues one cycle later.
- Simultaneous error sources in one cycle give a single o_err pulse.
- Reset mid-stream: o_tap_wr and o_busy drop immediately, no o_done is generated, and o_active_bank returns to 0. The FIR then holds a partially shifted tap set, and the integrator must reload.
- i_load held high: a new load starts on the edge after DONE returns to IDLE, with no error.
- Address counter: AW bits, down-count terminating at 0, with no wrap. Addresses >= NTAPS (non-power-of-two NTAPS) are never read. Host writes to them are discarded without error.

Decomposition:
- Shared package fir_pkg: the FSM state enum (IDLE/PRIME/STREAM/DONE) and a default coefficient width constant shared with the FIR.
- One sub-module: fir_coef_ram, a 2-bank simple dual-port RAM (one write port, one synchronous read port), inferable as block/distributed RAM.
- FSM, counter and error logic live in the top.

Test Plan:
- NTAPS=4, IW=12: write bank0 h={0x001,0x002,0x003,0x004}, pulse i_load bank0 at edge t -> o_tap_wr high at t+2..t+5 with o_tap=0x004,0x003,0x002,0x001. o_done pulses at t+6 with o_active_bank=0.
- Drive a 4-tap FIR model from the outputs with an impulse sample 0x001 -> outputs reproduce h[0..3]=1,2,3,4 in order. Negative coefficient 0x800 passes through unchanged.
- During a bank0 stream: write bank0 addr1 -> o_err pulse, data unchanged on the next load. Write bank1 addr1=0x7FF -> accepted, and a later bank1 load emits 0x7FF in the third write slot.
- i_load asserted at t+3 of an active stream -> o_err pulse at the next edge, and exactly 4 o_tap_wr pulses total.
- Assert i_reset asynchronously at t+3 -> o_tap_wr, o_busy and o_active_bank are 0 before the next edge, with no o_done. After release, a new load produces a full 4-write sequence.
- i_load held high continuously -> back-to-back loads separated only by the DONE cycle, and o_err never pulses.
